pc_fetch_unit: RTL

Program-counter and fetch-address stage sitting directly upstream of the hazard unit's pipeline registers. It consumes the hazard unit's `pc_WEN` and `npc_change` decisions and holds the architectural fetch PC. It drives the instruction-memory request and selects the next PC from, in priority order, halt freeze, redirect target, optional BTB prediction, and sequential PC+4. The PC and prediction are passed to the IF/ID latch.

---
 rtl/pc_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC register, next-PC selection and instruction-memory
// request. The next PC is chosen by priority: halt freeze, then redirect
// target, then BTB prediction, then sequential PC+4.
// Define PC_FETCH_BTB_EN to build the direct-mapped BTB. Without it, fetch is
// purely sequential and pred_taken is tied low.
module pc_fetch_unit #(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_WEN,
    input  logic        npc_change,
    input  logic [31:0] npc_target,
    input  logic        halt,
    input  logic        btb_wen,
    input  logic [31:0] btb_pc,
    input  logic [31:0] btb_target,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        halted
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    assign imemaddr = pc;
    assign pc_plus4 = pc + 32'd4;

`ifdef PC_FETCH_BTB_EN
    localparam int unsigned IW = $clog2(BTB_ENTRIES);
    localparam int unsigned TW = 30 - IW;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TW-1:0]          btb_tag [BTB_ENTRIES];
    logic [29:0]            btb_tgt [BTB_ENTRIES];
    logic [IW-1:0]          lk_idx;
    logic [IW-1:0]          wr_idx;
    logic                   unused_btb;

    assign lk_idx     = pc[2+IW-1:2];
    assign wr_idx     = btb_pc[2+IW-1:2];
    assign unused_btb = ^{btb_pc[1:0], btb_target[1:0], npc_target[1:0]};

    // Combinational lookup on the registered PC; writes land at the edge, so a
    // same-cycle write is only visible from the following cycle.
    always_comb begin
        pred_taken  = btb_valid[lk_idx] && (btb_tag[lk_idx] == pc[31:2+IW]);
        pred_target = pred_taken ? {btb_tgt[lk_idx], 2'b00} : pc_plus4;
    end

    // Valid bits: cleared by reset, set by an update (accepted even when halted).
    always_ff @(posedge CLK) begin
        if (RST) begin
            btb_valid <= '0;
        end else if (btb_wen) begin
            btb_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/target storage needs no reset; entries are qualified by the valid bit.
    always_ff @(posedge CLK) begin
        if (!RST && btb_wen) begin
            btb_tag[wr_idx] <= btb_pc[31:2+IW];
            btb_tgt[wr_idx] <= btb_target[31:2];
        end
    end
`else
    logic unused_btb;

    assign unused_btb = ^{btb_wen, btb_pc, btb_target, npc_target[1:0],
                          BTB_ENTRIES[0]};

    // No BTB: prediction is always the sequential PC.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
    end
`endif

    // Next-PC select: redirect beats prediction/sequential.
    always_comb begin
        next_pc = npc_change ? {npc_target[31:2], 2'b00} : pred_target;
    end

    // Fetch FSM: halt beats a same-cycle redirect; HALTED exits only via reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            pc      <= {PC_INIT[31:2], 2'b00};
            imemREN <= 1'b1;
            halted  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        state   <= HALTED;
                        imemREN <= 1'b0;
                        halted  <= 1'b1;
                    end else if (pc_WEN || npc_change) begin
                        pc <= next_pc;
                    end
                end
                HALTED: begin
                    imemREN <= 1'b0;
                    halted  <= 1'b1;
                end
                default: begin
                    state   <= RUN;
                    imemREN <= 1'b1;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule
